// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage scoreboard: per-register in-flight write counters, RAW and
// saturation stall generation, and the halt/dump drain sequencer.
module decode_hazard_scoreboard #(
   parameter int MAX_INFLIGHT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instrValid,
   input  logic [2:0] readReg1Sel,
   input  logic       readReg1Used,
   input  logic [2:0] readReg2Sel,
   input  logic       readReg2Used,
   input  logic [2:0] destReg,
   input  logic       regWriteDec,
   input  logic       haltDec,
   input  logic       flush,
   input  logic       wbValid,
   input  logic [2:0] wbReg,
   output logic       stall,
   output logic       issue,
   output logic [7:0] pending,
   output logic       halted,
   output logic       err
);

   localparam int CW = 2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_cnt [8];
   logic [CW-1:0] w_cnt_next [8];
   logic          r_err;

   logic [7:0]    w_wb_hit;
   logic [7:0]    w_cnt_nz;
   logic [7:0]    w_eff_nz;
   logic [7:0]    w_inc;
   logic [7:0]    w_dec;
   logic [7:0]    w_drain_nz;
   logic          w_sat;
   logic          w_hazard;
   logic          w_stall;
   logic          w_issue;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_reg
         assign w_wb_hit[gi] = wbValid && (wbReg == 3'(gi));
         assign w_cnt_nz[gi] = (r_cnt[gi] != '0);
         // Widened subtraction: a writeback to an empty counter reads as -1, not 0.
         assign w_eff_nz[gi] = (({1'b0, r_cnt[gi]} - {{CW{1'b0}}, w_wb_hit[gi]}) != '0);
         assign w_inc[gi] = w_issue && regWriteDec && (destReg == 3'(gi));
         assign w_dec[gi] = w_wb_hit[gi] && w_cnt_nz[gi];
         assign w_cnt_next[gi] = r_cnt[gi] + CW'(w_inc[gi]) - CW'(w_dec[gi]);
         // Nothing issues outside RUN, so the drain check only needs retirements.
         assign w_drain_nz[gi] = ((r_cnt[gi] - CW'(w_dec[gi])) != '0);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt[gi] <= '0;
            end else begin
               r_cnt[gi] <= w_cnt_next[gi];
            end
         end
      end
   endgenerate

   assign w_sat = (r_cnt[destReg] == CW'(MAX_INFLIGHT)) && !w_wb_hit[destReg];

   assign w_hazard = (readReg1Used && w_eff_nz[readReg1Sel]) ||
                     (readReg2Used && w_eff_nz[readReg2Sel]) ||
                     (regWriteDec && w_sat);

   always_comb begin
      w_stall      = 1'b0;
      w_issue      = 1'b0;
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            w_stall = instrValid && !flush && w_hazard;
            w_issue = instrValid && !flush && !w_hazard;
            if (w_issue && haltDec) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_stall = instrValid;
            if (w_drain_nz == 8'h00) begin
               w_state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            w_stall = instrValid;
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (wbValid && !w_cnt_nz[wbReg]) begin
         r_err <= 1'b1;
      end
   end

   assign stall   = w_stall;
   assign issue   = w_issue;
   assign pending = w_cnt_nz;
   assign halted  = (r_state == ST_HALTED);
   assign err     = r_err;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed plus randomized bench for decode_hazard_scoreboard against an
// integer-count reference model of the scoreboard rules.
module tb_decode_hazard_scoreboard;

   logic       clk;
   logic       rst;
   logic       instrValid;
   logic [2:0] readReg1Sel;
   logic       readReg1Used;
   logic [2:0] readReg2Sel;
   logic       readReg2Used;
   logic [2:0] destReg;
   logic       regWriteDec;
   logic       haltDec;
   logic       flush;
   logic       wbValid;
   logic [2:0] wbReg;
   logic       stall;
   logic       issue;
   logic [7:0] pending;
   logic       halted;
   logic       err;

   int checks = 0;
   int errors = 0;

   // Reference model: plain integer counts, 0=run 1=drain 2=halted.
   int m_cnt [8];
   int m_state;
   bit m_err;

   decode_hazard_scoreboard #(.MAX_INFLIGHT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .instrValid   (instrValid),
      .readReg1Sel  (readReg1Sel),
      .readReg1Used (readReg1Used),
      .readReg2Sel  (readReg2Sel),
      .readReg2Used (readReg2Used),
      .destReg      (destReg),
      .regWriteDec  (regWriteDec),
      .haltDec      (haltDec),
      .flush        (flush),
      .wbValid      (wbValid),
      .wbReg        (wbReg),
      .stall        (stall),
      .issue        (issue),
      .pending      (pending),
      .halted       (halted),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      instrValid   = 1'b0;
      readReg1Sel  = 3'd0;
      readReg1Used = 1'b0;
      readReg2Sel  = 3'd0;
      readReg2Used = 1'b0;
      destReg      = 3'd0;
      regWriteDec  = 1'b0;
      haltDec      = 1'b0;
      flush        = 1'b0;
      wbValid      = 1'b0;
      wbReg        = 3'd0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 8; r++) m_cnt[r] = 0;
      m_state = 0;
      m_err   = 1'b0;
   endtask

   // Called at posedge+1 with inputs already driven; checks one full cycle.
   task automatic cyc();
      int         nxt [8];
      int         tot;
      int         nstate;
      bit         nerr;
      bit         haz;
      logic       exp_stall;
      logic       exp_issue;
      logic [7:0] exp_pend;
      int         wb1;
      int         wb2;
      int         wbd;
      #2;
      wb1 = (wbValid && wbReg == readReg1Sel) ? 1 : 0;
      wb2 = (wbValid && wbReg == readReg2Sel) ? 1 : 0;
      wbd = (wbValid && wbReg == destReg) ? 1 : 0;
      haz = 1'b0;
      if (readReg1Used && (m_cnt[readReg1Sel] - wb1) != 0) haz = 1'b1;
      if (readReg2Used && (m_cnt[readReg2Sel] - wb2) != 0) haz = 1'b1;
      if (regWriteDec && m_cnt[destReg] == 3 && wbd == 0) haz = 1'b1;
      if (m_state == 0) begin
         exp_stall = instrValid && !flush && haz;
         exp_issue = instrValid && !flush && !haz;
      end else begin
         exp_stall = instrValid;
         exp_issue = 1'b0;
      end
      chk("stall", {7'b0, stall}, {7'b0, exp_stall});
      chk("issue", {7'b0, issue}, {7'b0, exp_issue});

      nerr = m_err;
      for (int r = 0; r < 8; r++) nxt[r] = m_cnt[r];
      if (exp_issue && regWriteDec) nxt[destReg] = nxt[destReg] + 1;
      if (wbValid) begin
         if (m_cnt[wbReg] > 0) nxt[wbReg] = nxt[wbReg] - 1;
         else nerr = 1'b1;
      end
      tot = 0;
      for (int r = 0; r < 8; r++) tot += nxt[r];
      nstate = m_state;
      if (m_state == 0 && exp_issue && haltDec) nstate = 1;
      else if (m_state == 1 && tot == 0) nstate = 2;

      @(posedge clk);
      #1;
      for (int r = 0; r < 8; r++) m_cnt[r] = nxt[r];
      m_state = nstate;
      m_err   = nerr;
      for (int r = 0; r < 8; r++) exp_pend[r] = (m_cnt[r] != 0);
      chk("pending", pending, exp_pend);
      chk("halted", {7'b0, halted}, {7'b0, (m_state == 2)});
      chk("err", {7'b0, err}, {7'b0, m_err});
   endtask

   // Reset asserted mid-cycle must clear state without waiting for an edge.
   task automatic async_reset();
      idle();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_pending", pending, 8'h00);
      chk("rst_halted", {7'b0, halted}, 8'h00);
      chk("rst_err", {7'b0, err}, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int start;
      idle();
      model_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("init_pending", pending, 8'h00);
      chk("init_halted", {7'b0, halted}, 8'h00);
      chk("init_err", {7'b0, err}, 8'h00);
      chk("init_stall", {7'b0, stall}, 8'h00);
      chk("init_issue", {7'b0, issue}, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back RAW on R3, resolved by same-cycle writeback.
      idle(); instrValid = 1; regWriteDec = 1; destReg = 3; cyc();
      idle(); instrValid = 1; readReg1Used = 1; readReg1Sel = 3; cyc(); cyc();
      wbValid = 1; wbReg = 3; cyc();

      // Same-cycle write and retire on R5.
      idle(); instrValid = 1; regWriteDec = 1; destReg = 5; cyc();
      wbValid = 1; wbReg = 5; cyc();
      chk("r5_pending", {7'b0, pending[5]}, 8'h01);
      idle(); wbValid = 1; wbReg = 5; cyc();

      // Saturation on R2.
      idle(); instrValid = 1; regWriteDec = 1; destReg = 2;
      repeat (3) cyc();
      cyc();
      wbValid = 1; wbReg = 2; cyc();
      idle(); wbValid = 1; wbReg = 2;
      repeat (3) cyc();

      // Flush beats a live Rs hazard.
      idle(); instrValid = 1; regWriteDec = 1; destReg = 1; cyc();
      idle(); instrValid = 1; flush = 1; readReg1Used = 1; readReg1Sel = 1;
      regWriteDec = 1; destReg = 7; cyc();

      // Halt drain with cnt[1]=1, cnt[6]=2.
      idle(); instrValid = 1; regWriteDec = 1; destReg = 6;
      repeat (2) cyc();
      idle(); instrValid = 1; haltDec = 1; cyc();
      idle(); instrValid = 1; cyc();
      wbValid = 1; wbReg = 1; cyc();
      wbReg = 6; cyc();
      cyc();
      idle(); instrValid = 1;
      repeat (3) cyc();
      chk("halt_hold", {7'b0, halted}, 8'h01);

      // Underflow on R4, then asynchronous reset.
      idle(); wbValid = 1; wbReg = 4; cyc();
      idle(); cyc();
      chk("err_sticky", {7'b0, err}, 8'h01);
      async_reset();

      // Randomized traffic, biased towards writebacks of live registers.
      for (int n = 0; n < 800; n++) begin
         if (n % 100 == 99) async_reset();
         instrValid   = ($urandom_range(0, 3) != 0);
         readReg1Sel  = 3'($urandom_range(0, 7));
         readReg1Used = ($urandom_range(0, 1) != 0);
         readReg2Sel  = 3'($urandom_range(0, 7));
         readReg2Used = ($urandom_range(0, 1) != 0);
         destReg      = 3'($urandom_range(0, 3));
         regWriteDec  = ($urandom_range(0, 2) != 0);
         haltDec      = ($urandom_range(0, 59) == 0);
         flush        = ($urandom_range(0, 9) == 0);
         wbValid      = ($urandom_range(0, 2) == 0);
         wbReg        = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) != 0) begin
            start = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
               if (m_cnt[(start + k) % 8] != 0) begin
                  wbReg = 3'((start + k) % 8);
                  break;
               end
            end
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_hazard_scoreboard.md
# decode_hazard_scoreboard

Scoreboard and stall controller for the decode stage. It tracks which of the eight architectural registers have a write in flight between decode and MEM_WB writeback, and stalls decode while an instruction reads a register whose value is not yet visible through the bypassing register file. It also sequences the halt/dump drain: after a halt instruction issues, it stalls until every in-flight write retires, then reports the processor halted.

## Interface
Parameters:
- MAX_INFLIGHT, default 3: maximum outstanding writes per register; sets counter width to 2 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- instrValid  input  1  decode holds a valid instruction this cycle.
- readReg1Sel  input  3  Rs index, instruction[10:8].
- readReg1Used  input  1  instruction actually reads Rs.
- readReg2Sel  input  3  Rt index, instruction[7:5].
- readReg2Used  input  1  instruction actually reads Rt.
- destReg  input  3  destination register chosen by control (RegDst).
- regWriteDec  input  1  decoded instruction writes destReg.
- haltDec  input  1  decoded instruction is a halt/dump.
- flush  input  1  decode instruction is squashed this cycle (branch redirect).
- wbValid  input  1  MEM_WB writes the register file this cycle.
- wbReg  input  3  MEM_WB write register.
- stall  output  1  hold the PC and IF/ID; insert a bubble into ID/EX.
- issue  output  1  the decode instruction advances this cycle.
- pending  output  8  bit i is set when cnt[i] != 0.
- halted  output  1  drain is complete; the processor is stopped.
- err  output  1  sticky error flag.

## Operation
- State: cnt[0..7] (2 bits each), FSM state {RUN, DRAIN, HALTED}, and the err flag.
- Effective count: eff[r] = cnt[r] - (wbValid && wbReg==r). The register file bypasses same-cycle writeback, so a retiring write clears its hazard in that cycle.
- hazard = (readReg1Used && eff[readReg1Sel]!=0) || (readReg2Used && eff[readReg2Sel]!=0) || (regWriteDec && cnt[destReg]==MAX_INFLIGHT && !(wbValid && wbReg==destReg)).
- RUN: stall = instrValid && !flush && hazard. issue = instrValid && !flush && !hazard.
- DRAIN and HALTED: stall = instrValid, and issue = 0.
- Counter update per register r:
  - inc = issue && regWriteDec && destReg==r.
  - dec = wbValid && wbReg==r && cnt[r]!=0.
  - The next value is cnt[r] + inc - dec. When inc and dec occur together, the count is unchanged.
- Underflow: wbValid with cnt[wbReg]==0 sets err. The counter stays at 0.
- err stays set until reset.
- FSM transitions:
  - RUN -> DRAIN when issue && haltDec. An issuing halt with regWriteDec still increments its counter.
  - DRAIN -> HALTED on the first edge where every next-state counter is 0. If all counters are already 0 when the halt issues, the FSM still spends one cycle in DRAIN.
  - HALTED is terminal until reset.
- flush has priority over hazard. A flushed instruction never issues, never stalls, and never increments a counter. Writes already in flight still decrement on writeback.

## Timing
- Reset values:
  - cnt = 0 and pending = 8'h00.
  - State = RUN.
  - halted = 0 and err = 0.
  - stall and issue are combinational, and both are 0 while instrValid = 0.
- stall and issue are combinational from the inputs and registered state, with zero-cycle latency. Counters and the FSM update at the following rising edge.
- pending and halted are registered, derived from current state, and have no input-to-output combinational path.
- Reset asserted mid-operation clears all state immediately and asynchronously. Release is synchronous to the next clk edge.

## Test plan
- Back-to-back RAW: issue a write to R3, then an instruction reading R3 as Rs.
  - The second instruction stalls until wbValid with wbReg=3.
  - It issues in that same wbValid cycle; stall is deasserted that cycle.
- Same-cycle write and retire: with cnt[5]=1, issue a new write to R5 while wbValid, wbReg=5 -> cnt[5] stays 1 and pending[5] stays 1.
- Saturation:
  - Issue three writes to R2 with no writeback -> cnt[2]=3.
  - A fourth write to R2 stalls.
  - Assert wbValid with wbReg=2 -> the fourth write issues in that cycle and cnt[2] stays 3.
- Flush: instrValid=1, flush=1, an Rs hazard present -> stall=0, issue=0, and counters are unchanged.
- Halt drain:
  - Start with cnt[1]=1 and cnt[6]=2, then issue a halt -> stall is held at 1.
  - Retire three writebacks -> halted rises one edge after the last writeback.
  - halted then remains 1.
- Underflow and reset:
  - wbValid with wbReg=4 while cnt[4]=0 -> err=1, and err remains set.
  - Drive rst=0 asynchronously mid-cycle -> err, cnt and halted all clear at once.
